lddw_imm_assembler: RTL and testbench

- Decode-side stage for the eBPF core. Sits directly upstream of the delayed-destination register and the register-file write port.
- Detects the two-slot `lddw` instruction (opcode 0x18). Latches dst and the low 32-bit immediate from slot 1, combines them with the high immediate from slot 2, and issues one 64-bit register write.
- All other instructions pass through unchanged, via a one-deep registered skid.

---
 rtl/lddw_imm_assembler.sv | 156 +++++++++++++++
 tb/tb_lddw_imm_assembler.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/lddw_imm_assembler.sv
// Decode-side assembler for the two-slot eBPF lddw: merges both immediates into one 64-bit register write.
// Optional build macro LDDW_STRICT_CHECK_EN rejects a second slot whose low word is not zero.
module lddw_imm_assembler #(
  parameter logic [7:0] LDDW_OPCODE = 8'h18,
  parameter int         INST_W      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              inst_valid,
  input  logic [INST_W-1:0] inst,
  output logic              inst_ready,
  output logic              pass_valid,
  output logic [INST_W-1:0] pass_inst,
  input  logic              pass_ready,
  output logic              wr_en,
  output logic [3:0]        wr_dst,
  output logic [63:0]       wr_data,
  output logic              busy,
  output logic              err_malformed
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT_HI = 1'b1} state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [3:0]    dst_r;
  logic [31:0]   imm_lo_r;
  logic          pass_valid_r;
  logic [INST_W-1:0] pass_inst_r;
  logic          wr_en_r;
  logic [3:0]    wr_dst_r;
  logic [63:0]   wr_data_r;
  logic          err_r;

  logic accept_s;
  logic is_lddw_s;
  logic malformed_s;
  logic wr_fire_s;
  logic err_fire_s;
  logic lo_load_s;
  logic pass_load_s;

  assign is_lddw_s = (inst[7:0] == LDDW_OPCODE);
  assign accept_s  = inst_valid && inst_ready;

`ifdef LDDW_STRICT_CHECK_EN
  assign malformed_s = (inst[31:0] != 32'h0000_0000);
`else
  assign malformed_s = 1'b0;
`endif

  // Ready depends only on state, skid occupancy, downstream ready and flush.
  always_comb begin
    inst_ready = 1'b0;
    if (flush) begin
      inst_ready = 1'b0;
    end else if (state_r == WAIT_HI) begin
      inst_ready = 1'b1;
    end else begin
      inst_ready = !pass_valid_r || pass_ready;
    end
  end

  // Next-state and per-edge action decode.
  always_comb begin
    state_nxt_s = state_r;
    wr_fire_s   = 1'b0;
    err_fire_s  = 1'b0;
    lo_load_s   = 1'b0;
    pass_load_s = 1'b0;
    if (flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && is_lddw_s) begin
            state_nxt_s = WAIT_HI;
            lo_load_s   = 1'b1;
          end else if (accept_s) begin
            pass_load_s = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        WAIT_HI: begin
          // Slot 2 is pure data even if its low byte looks like an lddw opcode.
          if (accept_s) begin
            state_nxt_s = IDLE;
            if (malformed_s) begin
              err_fire_s = 1'b1;
            end else begin
              wr_fire_s = 1'b1;
            end
          end else begin
            state_nxt_s = WAIT_HI;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath registers: slot-1 latch, write port, pass-through skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      dst_r        <= 4'h0;
      imm_lo_r     <= 32'h0000_0000;
      wr_en_r      <= 1'b0;
      wr_dst_r     <= 4'h0;
      wr_data_r    <= 64'h0;
      err_r        <= 1'b0;
      pass_valid_r <= 1'b0;
      pass_inst_r  <= '0;
    end else begin
      wr_en_r <= wr_fire_s;
      err_r   <= err_fire_s;
      if (lo_load_s) begin
        dst_r    <= inst[11:8];
        imm_lo_r <= inst[63:32];
      end
      if (wr_fire_s) begin
        wr_dst_r  <= dst_r;
        wr_data_r <= {inst[INST_W-1:32], imm_lo_r};
      end
      if (flush) begin
        pass_valid_r <= 1'b0;
      end else if (pass_load_s) begin
        pass_valid_r <= 1'b1;
        pass_inst_r  <= inst;
      end else if (pass_ready) begin
        pass_valid_r <= 1'b0;
      end
    end
  end

  assign pass_valid    = pass_valid_r;
  assign pass_inst     = pass_inst_r;
  assign wr_en         = wr_en_r;
  assign wr_dst        = wr_dst_r;
  assign wr_data       = wr_data_r;
  assign err_malformed = err_r;
  assign busy          = (state_r == WAIT_HI);

endmodule

// File: tb/tb_lddw_imm_assembler.sv
// Directed table-driven bench for lddw_imm_assembler, plus hand sequences for flush and slot-2 check.
module tb_lddw_imm_assembler;

  logic        clk = 1'b0;
  logic        rst, flush, inst_valid, pass_ready;
  logic [63:0] inst;
  logic        inst_ready, pass_valid, wr_en, busy, err_malformed;
  logic [63:0] pass_inst, wr_data;
  logic [3:0]  wr_dst;

  int tests = 0;
  int fails = 0;
  int fwd_cnt = 0;

  lddw_imm_assembler dut (
    .clk(clk), .rst(rst), .flush(flush), .inst_valid(inst_valid), .inst(inst),
    .inst_ready(inst_ready), .pass_valid(pass_valid), .pass_inst(pass_inst),
    .pass_ready(pass_ready), .wr_en(wr_en), .wr_dst(wr_dst), .wr_data(wr_data),
    .busy(busy), .err_malformed(err_malformed)
  );

  always #5 clk = ~clk;

  // Count downstream handshakes to prove each word leaves exactly once.
  always @(posedge clk) begin
    if (!rst && pass_valid && pass_ready) fwd_cnt <= fwd_cnt + 1;
  end

  typedef struct {
    logic        v;
    logic [63:0] w;
    logic        pr;
    logic        fl;
    logic        e_rdy;
    logic        e_wen;
    logic [3:0]  e_dst;
    logic [63:0] e_data;
    logic        e_pv;
    logic [63:0] e_pinst;
    logic        e_busy;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] w, input logic pr, input logic fl);
    inst_valid = v; inst = w; pass_ready = pr; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            v     inst                    pr    fl    rdy   wen   dst   data                    pv    pinst                   busy
    vecs[0]  = '{1'b0, 64'h0,                  1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 64'h0,                  1'b0, 64'h0,                  1'b0};
    vecs[1]  = '{1'b1, 64'h11223344_0000_0318, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 64'h0,                  1'b0, 64'h0,                  1'b1};
    vecs[2]  = '{1'b1, 64'hAABBCCDD_00000000,  1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 64'hAABBCCDD11223344,   1'b0, 64'h0,                  1'b0};
    vecs[3]  = '{1'b0, 64'h0,                  1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 64'hAABBCCDD11223344,   1'b0, 64'h0,                  1'b0};
    vecs[4]  = '{1'b1, 64'h00000005_0000_01B7, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 64'hAABBCCDD11223344,   1'b1, 64'h00000005_0000_01B7, 1'b0};
    vecs[5]  = '{1'b1, 64'h00000009_0000_04B7, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 64'hAABBCCDD11223344,   1'b1, 64'h00000005_0000_01B7, 1'b0};
    vecs[6]  = '{1'b1, 64'h00000009_0000_04B7, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 64'hAABBCCDD11223344,   1'b1, 64'h00000005_0000_01B7, 1'b0};
    vecs[7]  = '{1'b0, 64'h0,                  1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 64'hAABBCCDD11223344,   1'b0, 64'h0,                  1'b0};
    vecs[8]  = '{1'b1, 64'h11223344_0000_0518, 1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 64'hAABBCCDD11223344,   1'b0, 64'h0,                  1'b1};
    vecs[9]  = '{1'b0, 64'h0,                  1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 64'hAABBCCDD11223344,   1'b0, 64'h0,                  1'b0};
    vecs[10] = '{1'b1, 64'h00000007_0000_02B7, 1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 64'hAABBCCDD11223344,   1'b1, 64'h00000007_0000_02B7, 1'b0};
    vecs[11] = '{1'b0, 64'h0,                  1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 64'hAABBCCDD11223344,   1'b0, 64'h0,                  1'b0};
    vecs[12] = '{1'b1, 64'hDEADBEEF_0000_0718, 1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 64'hAABBCCDD11223344,   1'b0, 64'h0,                  1'b1};
    vecs[13] = '{1'b1, 64'h01020304_00000000,  1'b1, 1'b0, 1'b1, 1'b1, 4'h7, 64'h01020304DEADBEEF,   1'b0, 64'h0,                  1'b0};
    vecs[14] = '{1'b1, 64'hCAFEF00D_0000_0918, 1'b1, 1'b0, 1'b1, 1'b0, 4'h7, 64'h01020304DEADBEEF,   1'b0, 64'h0,                  1'b1};
    vecs[15] = '{1'b1, 64'h0A0B0C0D_00000000,  1'b1, 1'b0, 1'b1, 1'b1, 4'h9, 64'h0A0B0C0DCAFEF00D,   1'b0, 64'h0,                  1'b0};
    vecs[16] = '{1'b1, 64'h00000001_0000_03B7, 1'b1, 1'b0, 1'b1, 1'b0, 4'h9, 64'h0A0B0C0DCAFEF00D,   1'b1, 64'h00000001_0000_03B7, 1'b0};
    vecs[17] = '{1'b1, 64'h00000002_0000_06B7, 1'b1, 1'b0, 1'b1, 1'b0, 4'h9, 64'h0A0B0C0DCAFEF00D,   1'b1, 64'h00000002_0000_06B7, 1'b0};
    vecs[18] = '{1'b0, 64'h0,                  1'b1, 1'b0, 1'b1, 1'b0, 4'h9, 64'h0A0B0C0DCAFEF00D,   1'b0, 64'h0,                  1'b0};

    rst = 1'b1;
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_pass_valid", {63'h0, pass_valid}, 64'h0);
    check("rst_pass_inst", pass_inst, 64'h0);
    check("rst_wr_en", {63'h0, wr_en}, 64'h0);
    check("rst_wr_dst", {60'h0, wr_dst}, 64'h0);
    check("rst_wr_data", wr_data, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_err", {63'h0, err_malformed}, 64'h0);
    check("rst_inst_ready", {63'h0, inst_ready}, 64'h1);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].v, vecs[i].w, vecs[i].pr, vecs[i].fl);
      #1;
      check($sformatf("v%0d_inst_ready", i), {63'h0, inst_ready}, {63'h0, vecs[i].e_rdy});
      tick();
      check($sformatf("v%0d_wr_en", i), {63'h0, wr_en}, {63'h0, vecs[i].e_wen});
      check($sformatf("v%0d_wr_dst", i), {60'h0, wr_dst}, {60'h0, vecs[i].e_dst});
      check($sformatf("v%0d_wr_data", i), wr_data, vecs[i].e_data);
      check($sformatf("v%0d_pass_valid", i), {63'h0, pass_valid}, {63'h0, vecs[i].e_pv});
      if (vecs[i].e_pv) check($sformatf("v%0d_pass_inst", i), pass_inst, vecs[i].e_pinst);
      check($sformatf("v%0d_busy", i), {63'h0, busy}, {63'h0, vecs[i].e_busy});
      check($sformatf("v%0d_err", i), {63'h0, err_malformed}, 64'h0);
    end
    check("table_fwd_count", fwd_cnt, 64'd4);

    // Slot 2 carrying an lddw opcode and a nonzero low word.
    drive(1'b1, 64'h55667788_0000_0418, 1'b1, 1'b0); tick();
    drive(1'b1, 64'h00000001_00000018, 1'b1, 1'b0); tick();
`ifdef LDDW_STRICT_CHECK_EN
    check("mal_err", {63'h0, err_malformed}, 64'h1);
    check("mal_wr_en", {63'h0, wr_en}, 64'h0);
    check("mal_wr_dst_held", {60'h0, wr_dst}, 64'h9);
`else
    check("mal_err", {63'h0, err_malformed}, 64'h0);
    check("mal_wr_en", {63'h0, wr_en}, 64'h1);
    check("mal_wr_dst", {60'h0, wr_dst}, 64'h4);
    check("mal_wr_data", wr_data, 64'h0000000155667788);
`endif
    check("mal_busy", {63'h0, busy}, 64'h0);
    drive(1'b0, 64'h0, 1'b1, 1'b0); tick();
    check("mal_err_pulse", {63'h0, err_malformed}, 64'h0);
    check("mal_wr_en_pulse", {63'h0, wr_en}, 64'h0);
    check("mal_pass_valid", {63'h0, pass_valid}, 64'h0);

    // Skid drains while slot 1 is accepted; then flush vs. a visible write.
    drive(1'b1, 64'h00000003_0000_0AB7, 1'b0, 1'b0); tick();
    check("h_pv_load", {63'h0, pass_valid}, 64'h1);
    drive(1'b1, 64'h0BADF00D_0000_0818, 1'b1, 1'b0); #1;
    check("h_rdy_drain", {63'h0, inst_ready}, 64'h1);
    tick();
    check("h_busy", {63'h0, busy}, 64'h1);
    check("h_pv_drained", {63'h0, pass_valid}, 64'h0);
    drive(1'b1, 64'h12345678_00000000, 1'b1, 1'b0); tick();
    check("h_wr_en", {63'h0, wr_en}, 64'h1);
    check("h_wr_data", wr_data, 64'h123456780BADF00D);
    check("h_wr_dst", {60'h0, wr_dst}, 64'h8);
    drive(1'b1, 64'h00000004_0000_0BB7, 1'b0, 1'b1); #1;
    check("h_flush_rdy", {63'h0, inst_ready}, 64'h0);
    check("h_flush_keeps_wr_en", {63'h0, wr_en}, 64'h1);
    tick();
    check("h_flush_pv", {63'h0, pass_valid}, 64'h0);
    check("h_flush_wr_en", {63'h0, wr_en}, 64'h0);
    drive(1'b1, 64'h00000004_0000_0BB7, 1'b0, 1'b0); tick();
    check("h_pv_again", {63'h0, pass_valid}, 64'h1);
    drive(1'b0, 64'h0, 1'b0, 1'b1); tick();
    check("h_flush_drop_pv", {63'h0, pass_valid}, 64'h0);
    check("h_flush_busy", {63'h0, busy}, 64'h0);
    drive(1'b0, 64'h0, 1'b1, 1'b0); tick();
    check("h_pv_stays_low", {63'h0, pass_valid}, 64'h0);
    check("total_fwd_count", fwd_cnt, 64'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
